// File: rtl/dq_tx_pkg.sv
// Shared encodings for the DDR3 write-path byte-lane sequencer: FSM states,
// tristate codes and DQS waveforms.
package dq_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WAIT = 3'd1;
  localparam state_t S_PRE  = 3'd2;
  localparam state_t S_DATA = 3'd3;
  localparam state_t S_POST = 3'd4;

  localparam logic [1:0] TRI_OFF    = 2'b11;
  localparam logic [1:0] TRI_ON     = 2'b00;
  localparam logic [3:0] DQS_TOGGLE = 4'b1010;
  localparam logic [3:0] DQS_LOW    = 4'b0000;

endpackage

// File: rtl/dq_tx_lane_order.sv
// Per-lane nibble reorder ahead of the output serializer: pass-through when
// bit 0 leaves first, bit-reversed when bit 3 leaves first.
module dq_tx_lane_order #(
  parameter int MSB_FIRST = 0
) (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  generate
    if (MSB_FIRST != 0) begin : g_rev
      assign nib_o = {nib_i[0], nib_i[1], nib_i[2], nib_i[3]};
    end else begin : g_pass
      assign nib_o = nib_i;
    end
  endgenerate

endmodule

// File: rtl/dq_tx_sequencer.sv
// DDR3 write-path byte-lane sequencer: write latency, DQS preamble/postamble and
// per-lane bit order. Optional macro DQ_TX_PATTERN_EN adds a fixed-pattern burst source.
module dq_tx_sequencer
  import dq_tx_pkg::*;
#(
  parameter int DQ_WIDTH     = 8,
  parameter int WLAT_WIDTH   = 4,
  parameter int BURST_CYCLES = 2,
  parameter int MSB_FIRST    = 0
) (
  input  logic                    oclk_div,
  input  logic                    rst,
  input  logic [WLAT_WIDTH-1:0]   wlat,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4*DQ_WIDTH-1:0]   wr_data,
  output logic                    data_rd,
`ifdef DQ_TX_PATTERN_EN
  input  logic                    pattern_mode,
  input  logic [4*DQ_WIDTH-1:0]   pattern,
`endif
  output logic [4*DQ_WIDTH-1:0]   dq_dout,
  output logic [1:0]              dq_tri,
  output logic [3:0]              dqs_dout,
  output logic [1:0]              dqs_tri,
  output logic                    busy
);

  localparam int BCNT_W = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [WLAT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic                    pat_q, pat_d;

  logic [4*DQ_WIDTH-1:0]   src_data;
  logic [4*DQ_WIDTH-1:0]   ordered;

  logic [4*DQ_WIDTH-1:0]   dq_dout_q, dq_dout_d;
  logic [1:0]              dq_tri_q, dq_tri_d;
  logic [3:0]              dqs_dout_q, dqs_dout_d;
  logic [1:0]              dqs_tri_q, dqs_tri_d;

`ifdef DQ_TX_PATTERN_EN
  assign src_data = pat_q ? pattern : wr_data;
  assign data_rd  = (state_q == S_DATA) && !pat_q;
`else
  assign src_data = wr_data;
  assign data_rd  = (state_q == S_DATA);
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  genvar g;
  generate
    for (g = 0; g < DQ_WIDTH; g++) begin : g_lane
      dq_tx_lane_order #(.MSB_FIRST(MSB_FIRST)) u_order (
        .nib_i (src_data[4*g +: 4]),
        .nib_o (ordered[4*g +: 4])
      );
    end
  endgenerate

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    pat_d   = pat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = wlat;
`ifdef DQ_TX_PATTERN_EN
          pat_d   = pattern_mode;
`else
          pat_d   = 1'b0;
`endif
          state_d = (wlat != '0) ? S_WAIT : S_PRE;
        end
      end
      S_WAIT: begin
        // Leaving at cnt == 1 gives exactly wlat WAIT cycles and never wraps.
        cnt_d = cnt_q - WLAT_WIDTH'(1);
        if (cnt_q == WLAT_WIDTH'(1)) state_d = S_PRE;
      end
      S_PRE: begin
        bcnt_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (bcnt_q == LAST_BEAT) begin
          bcnt_d  = '0;
          state_d = S_POST;
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      S_POST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dq_dout_d  = '0;
    dq_tri_d   = TRI_OFF;
    dqs_dout_d = DQS_LOW;
    dqs_tri_d  = TRI_OFF;
    case (state_q)
      S_PRE, S_POST: dqs_tri_d = TRI_ON;
      S_DATA: begin
        dqs_tri_d  = TRI_ON;
        dqs_dout_d = DQS_TOGGLE;
        dq_tri_d   = TRI_ON;
        dq_dout_d  = ordered;
      end
      default: ;
    endcase
  end

  always_ff @(posedge oclk_div or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      pat_q      <= 1'b0;
      dq_dout_q  <= '0;
      dq_tri_q   <= TRI_OFF;
      dqs_dout_q <= DQS_LOW;
      dqs_tri_q  <= TRI_OFF;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge state.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      pat_q      <= pat_d;
      dq_dout_q  <= dq_dout_d;
      dq_tri_q   <= dq_tri_d;
      dqs_dout_q <= dqs_dout_d;
      dqs_tri_q  <= dqs_tri_d;
    end
  end

  assign dq_dout  = dq_dout_q;
  assign dq_tri   = dq_tri_q;
  assign dqs_dout = dqs_dout_q;
  assign dqs_tri  = dqs_tri_q;

endmodule

// File: tb/tb_dq_tx_sequencer.sv
// Directed scoreboard bench for dq_tx_sequencer; an LSB-first and an MSB-first
// instance share one stimulus stream.
module tb_dq_tx_sequencer;

  localparam int K_IDLE = 0;
  localparam int K_PRE  = 1;
  localparam int K_DATA = 2;
  localparam int K_POST = 3;

  logic        oclk_div = 1'b0;
  logic        rst      = 1'b1;
  logic [3:0]  wlat     = '0;
  logic        cmd_valid = 1'b0;
  logic [31:0] wr_data  = '0;

  logic        cmd_ready, data_rd, busy;
  logic [31:0] dq_dout;
  logic [1:0]  dq_tri, dqs_tri;
  logic [3:0]  dqs_dout;

  logic        m_cmd_ready, m_data_rd, m_busy;
  logic [31:0] m_dq_dout;
  logic [1:0]  m_dq_tri, m_dqs_tri;
  logic [3:0]  m_dqs_dout;

  always #5 oclk_div = ~oclk_div;

  dq_tx_sequencer #(.DQ_WIDTH(8), .WLAT_WIDTH(4), .BURST_CYCLES(2), .MSB_FIRST(0)) dut (
    .oclk_div (oclk_div), .rst (rst), .wlat (wlat), .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready), .wr_data (wr_data), .data_rd (data_rd),
    .dq_dout (dq_dout), .dq_tri (dq_tri), .dqs_dout (dqs_dout),
    .dqs_tri (dqs_tri), .busy (busy)
`ifdef DQ_TX_PATTERN_EN
    , .pattern_mode (1'b0), .pattern (32'h0)
`endif
  );

  dq_tx_sequencer #(.DQ_WIDTH(8), .WLAT_WIDTH(4), .BURST_CYCLES(2), .MSB_FIRST(1)) dut_msb (
    .oclk_div (oclk_div), .rst (rst), .wlat (wlat), .cmd_valid (cmd_valid),
    .cmd_ready (m_cmd_ready), .wr_data (wr_data), .data_rd (m_data_rd),
    .dq_dout (m_dq_dout), .dq_tri (m_dq_tri), .dqs_dout (m_dqs_dout),
    .dqs_tri (m_dqs_tri), .busy (m_busy)
`ifdef DQ_TX_PATTERN_EN
    , .pattern_mode (1'b0), .pattern (32'h0)
`endif
  );

  typedef struct {
    logic [31:0] dq;
    logic [31:0] dq_r;
    logic [1:0]  dqt;
    logic [3:0]  dqs;
    logic [1:0]  dqst;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev_nibbles(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 4; b++)
        r[4*l+b] = d[4*l+3-b];
    return r;
  endfunction

  function automatic exp_t mk(input int kind, input logic [31:0] d, input logic rdy);
    exp_t e;
    e.dq = '0; e.dq_r = '0; e.dqt = 2'b11; e.dqs = 4'b0000; e.dqst = 2'b11; e.rdy = rdy;
    if (kind == K_PRE || kind == K_POST) e.dqst = 2'b00;
    if (kind == K_DATA) begin
      e.dqst = 2'b00; e.dqs = 4'b1010; e.dqt = 2'b00;
      e.dq = d; e.dq_r = rev_nibbles(d);
    end
    return e;
  endfunction

  task automatic compare_cycle();
    exp_t e;
    e = sb.pop_front();
    check("dq_dout",     dq_dout,   e.dq);
    check("dq_dout_msb", m_dq_dout, e.dq_r);
    check("dq_tri",      dq_tri,    e.dqt);
    check("dqs_dout",    dqs_dout,  e.dqs);
    check("dqs_tri",     dqs_tri,   e.dqst);
    check("cmd_ready",   cmd_ready, e.rdy);
    check("busy",        busy,      !e.rdy);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after POST
  // outputs, or at the first DATA cycle when abort is set.
  task automatic burst(input logic [3:0] w, input logic [31:0] d0, input logic [31:0] d1,
                       input bit hold, input bit abort);
    int rd_cnt;
    rd_cnt = 0;
    check("ready_before_cmd", cmd_ready, 1'b1);
    wlat = w;
    cmd_valid = 1'b1;
    for (int i = 0; i < int'(w); i++) sb.push_back(mk(K_IDLE, '0, 1'b0));
    sb.push_back(mk(K_PRE,  '0, 1'b0));
    sb.push_back(mk(K_DATA, d0, 1'b0));
    sb.push_back(mk(K_DATA, d1, 1'b0));
    sb.push_back(mk(K_POST, '0, 1'b1));
    @(posedge oclk_div); #1;
    if (!hold) cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    for (int k = 1; k <= int'(w) + 4; k++) begin
      if (data_rd) begin
        wr_data = (rd_cnt == 0) ? d0 : d1;
        rd_cnt++;
        if (abort) return;
      end else begin
        wr_data = $urandom;
      end
      @(posedge oclk_div); #1;
      compare_cycle();
    end
    check("data_rd_beats", rd_cnt, 2);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge oclk_div); #1;
    check({tag, "_dq_tri"},  dq_tri,  2'b11);
    check({tag, "_dqs_tri"}, dqs_tri, 2'b11);
    check({tag, "_ready"},   cmd_ready, 1'b1);
    check({tag, "_busy"},    busy, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge oclk_div);
    #1;
    check("rst_dq_tri",   dq_tri,   2'b11);
    check("rst_dqs_tri",  dqs_tri,  2'b11);
    check("rst_dq_dout",  dq_dout,  32'h0);
    check("rst_dqs_dout", dqs_dout, 4'h0);
    check("rst_ready",    cmd_ready, 1'b1);
    check("rst_busy",     busy, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) idle_cycle("idle");

    burst(4'd3, 32'h11223344, 32'h55667788, 1'b0, 1'b0);
    idle_cycle("after_wlat3");

    burst(4'd0, 32'h00000001, 32'hA5C30F96, 1'b0, 1'b0);
    idle_cycle("after_wlat0");

    // cmd_valid stays high: the second command may only be taken once back in IDLE.
    burst(4'd2, 32'hDEADBEEF, 32'h0F1E2D3C, 1'b1, 1'b0);
    burst(4'd1, 32'h89ABCDEF, 32'h76543210, 1'b0, 1'b0);
    idle_cycle("after_hold");

    // Abort in the first DATA cycle with an asynchronous reset pulse.
    burst(4'd2, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b1);
    sb.delete();
    check("pre_rst_dqs_tri", dqs_tri, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("async_dq_tri",   dq_tri,   2'b11);
    check("async_dqs_tri",  dqs_tri,  2'b11);
    check("async_dqs_dout", dqs_dout, 4'h0);
    check("async_dq_dout",  dq_dout,  32'h0);
    check("async_msb_tri",  m_dq_tri, 2'b11);
    check("async_busy",     busy, 1'b0);
    check("async_ready",    cmd_ready, 1'b1);
    check("async_data_rd",  data_rd, 1'b0);
    #3 rst = 1'b0;
    idle_cycle("post_rst");
    idle_cycle("post_rst");

    burst(4'd4, 32'h0BADC0DE, 32'hFEEDFACE, 1'b0, 1'b0);
    idle_cycle("after_fresh");

    burst(4'd15, 32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b0);
    idle_cycle("after_wlat_max");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dq_tx_sequencer.md
Name: dq_tx_sequencer

Overview:
DDR3 write-path byte-lane sequencer. It runs on the divided memory clock and converts a write command plus parallel burst data into per-cycle 4-bit-per-lane DQ/DQS data and tristate words. The outputs feed the oserdes_mem output serializers; this block is the transmit counterpart of the read-side iserdes_mem capture. It handles write-latency delay, DQS preamble/postamble and bit ordering.

Parameters:
DQ_WIDTH, 8, number of DQ lanes in the byte lane.
WLAT_WIDTH, 4, width of the write-latency count input.
BURST_CYCLES, 2, oclk_div cycles of data per burst (BL8 = 2 x 4 bits).
MSB_FIRST, 0, 0: bit 0 of each lane nibble goes out first; 1: bit 3 goes out first.

Ports:
oclk_div  in  1  sole clock; divided memory clock; all logic on rising edge.
rst  in  1  reset; asynchronous, active-high.
wlat  in  WLAT_WIDTH  cycles from command accept to preamble; sampled on accept.
cmd_valid  in  1  write command request.
cmd_ready  out  1  high only in IDLE.
wr_data  in  4*DQ_WIDTH  burst data for one cycle; lane i occupies bits [4i+3:4i], bit 0 earliest.
data_rd  out  1  high in the cycle wr_data is consumed (combinational from state).
dq_dout  out  4*DQ_WIDTH  parallel DQ data to the serializers; registered.
dq_tri  out  2  DQ tristate, one bit per half-cycle; 1 = high-Z.
dqs_dout  out  4  parallel DQS data.
dqs_tri  out  2  DQS tristate.
busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, WAIT, PRE, DATA, POST.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch wlat into cnt.
  - Next state: WAIT if wlat != 0; otherwise PRE.
- WAIT:
  - cnt decrements each cycle.
  - When cnt == 1, next state is PRE, so PRE starts exactly wlat cycles after accept.
- PRE: one cycle, then DATA.
- DATA:
  - BURST_CYCLES cycles, counted by beat counter bcnt.
  - data_rd = 1 in every DATA cycle; wr_data is sampled in the same cycle.
  - After the last beat, next state is POST.
- POST: one cycle, then IDLE.
- Commands arriving outside IDLE are not accepted; cmd_ready = 0 stalls the source. There is no back-to-back merging.
- Outputs are registered from the current state, so output latency is 1 cycle after the state.
- IDLE/WAIT outputs: dq_tri = 11, dqs_tri = 11, dq_dout = 0, dqs_dout = 0000.
- PRE outputs: dqs_tri = 00, dqs_dout = 0000 (driven-low preamble), dq_tri = 11.
- DATA outputs:
  - dqs_tri = 00, dqs_dout = 4'b1010 (low first, toggling).
  - dq_tri = 00.
  - dq_dout = wr_data, each lane nibble bit-reversed when MSB_FIRST = 1.
- POST outputs: dqs_tri = 00, dqs_dout = 0000, dq_tri = 11.
- Reset values: state IDLE, cnt = 0, bcnt = 0, dq_dout = 0, dqs_dout = 0, dq_tri = 11, dqs_tri = 11, busy = 0, cmd_ready = 1.
- rst asserted mid-burst: all outputs return immediately to reset values (bus released to high-Z). No partial burst resumes after reset.
- wlat = 2^WLAT_WIDTH-1: the counter must not wrap; the maximum value gives exactly that many WAIT cycles.

Optional Feature:
DQ_TX_PATTERN_EN:
- Defined: adds input pattern_mode (1) and input pattern (4*DQ_WIDTH).
  - When pattern_mode is sampled high at command accept, the whole burst drives pattern in every DATA cycle.
  - data_rd stays 0 for that burst.
  - pattern_mode is ignored mid-burst.
- Undefined: the ports are absent and data always comes from wr_data.

Decomposition:
- Package dq_tx_pkg holds:
  - state enum (IDLE, WAIT, PRE, DATA, POST);
  - constants TRI_OFF = 2'b11, TRI_ON = 2'b00, DQS_TOGGLE = 4'b1010, DQS_LOW = 4'b0000.
- One sub-module, dq_tx_lane_order: combinational per-lane nibble reorder controlled by MSB_FIRST, instantiated DQ_WIDTH times.

Test Plan:
- Reset, then idle for 10 cycles -> dq_tri = dqs_tri = 11, cmd_ready = 1, busy = 0 throughout.
- cmd_valid with wlat = 3, wr_data = 0x11223344 then 0x55667788 -> PRE outputs 4 cycles after accept; next 2 cycles dq_dout = those words, dqs_dout = 1010; then one POST cycle; then tri = 11.
- wlat = 0 -> PRE outputs 1 cycle after accept; data_rd high for exactly 2 cycles.
- MSB_FIRST = 1, lane 0 nibble 4'b0001 -> dq_dout lane 0 = 4'b1000.
- cmd_valid held high during a burst -> second command accepted only in the cycle after POST (state IDLE); no overlap.
- rst asserted during the 1st DATA cycle -> dq_tri/dqs_tri = 11 asynchronously; after release, the next command starts a fresh burst with correct wlat.
